// File: rtl/shift_reg_pkg.sv
// Shared types and constants for the shift_reg_lr_ctrl block.
// Optional rotate support is enabled by defining SHIFT_REG_ROTATE_EN.
package shift_reg_pkg;

  // Controller states: IDLE accepts commands, SHIFT runs a multi-cycle shift.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Direction encoding, matching the shift_left_right input.
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // Selects the bit entering the vacated end. When rotating, the bit that
  // leaves one end re-enters at the other; otherwise the serial input is used.
  function automatic logic fill_select(
    input logic rot,
    input logic dir,
    input logic msb,
    input logic lsb,
    input logic serial_in
  );
    logic fill;
    fill = serial_in;
    if (rot) begin
      fill = (dir == DIR_LEFT) ? msb : lsb;
    end
    return fill;
  endfunction

endpackage

// File: rtl/shift_reg_lr_ctrl_core.sv
// Datapath of the shift register: holds q and serial_out and performs at most
// one operation per clock (parallel load has priority over a shift).
module shift_reg_lr_ctrl_core
  import shift_reg_pkg::*;
#(
  parameter int REG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_en,
  input  logic                 shift_en,
  input  logic                 dir,
  input  logic                 fill,
  input  logic [REG_WIDTH-1:0] data_in,
  output logic [REG_WIDTH-1:0] q,
  output logic                 serial_out
);

  // Register update: load, single-bit shift, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q          <= '0;
      serial_out <= 1'b0;
    end else if (load_en) begin
      // serial_out is deliberately untouched by a load.
      q <= data_in;
    end else if (shift_en) begin
      if (dir == DIR_LEFT) begin
        q          <= {q[REG_WIDTH-2:0], fill};
        serial_out <= q[REG_WIDTH-1];
      end else begin
        q          <= {fill, q[REG_WIDTH-1:1]};
        serial_out <= q[0];
      end
    end
  end

endmodule

// File: rtl/shift_reg_lr_ctrl.sv
// Shift-left/right register with parallel load and a valid/ready command port.
// Optional feature macro: SHIFT_REG_ROTATE_EN adds a `rotate` input.
//
// Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is high only in IDLE; commands offered while it is low are dropped
// (no queueing). Every accepted command ends with exactly one done pulse,
// unless reset intervenes.
module shift_reg_lr_ctrl
  import shift_reg_pkg::*;
#(
  parameter  int REG_WIDTH = 8,
  localparam int CNT_W     = $clog2(REG_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 load,
  input  logic                 shift_left_right,
  input  logic [REG_WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0]     shift_cnt,
  input  logic                 serial_in,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic                 rotate,
`endif
  output logic [REG_WIDTH-1:0] q,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 done
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             dir_q;
  logic             rot_q;
  logic             accept;
  logic             load_en;
  logic             shift_en;
  logic             fill;

  assign accept   = cmd_valid && (state == IDLE);
  assign load_en  = accept && load;
  assign shift_en = (state == SHIFT);

  // Status outputs decode straight from the state register.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state == SHIFT);

  // Fill bit uses the current register contents, never the live inputs other
  // than serial_in, so no input reaches an output combinationally.
  assign fill = fill_select(rot_q, dir_q, q[REG_WIDTH-1], q[0], serial_in);

  // Controller: command acceptance, shift counting and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      dir_q  <= DIR_RIGHT;
      rot_q  <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            if (load) begin
              done <= 1'b1;
            end else if (shift_cnt == '0) begin
              // Zero-length shift completes immediately as a no-op.
              done <= 1'b1;
            end else begin
              // No shift on the accept edge; shifting starts next edge.
              cnt   <= shift_cnt;
              dir_q <= shift_left_right;
`ifdef SHIFT_REG_ROTATE_EN
              rot_q <= rotate;
`else
              rot_q <= 1'b0;
`endif
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

  shift_reg_lr_ctrl_core #(
    .REG_WIDTH(REG_WIDTH)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .shift_en   (shift_en),
    .dir        (dir_q),
    .fill       (fill),
    .data_in    (data_in),
    .q          (q),
    .serial_out (serial_out)
  );

endmodule

// File: tb/tb_shift_reg_lr_ctrl.sv
// Bench for shift_reg_lr_ctrl (REG_WIDTH=8): directed vector table, hand
// sequences for reset/busy corner cases, and a randomized cycle-level run
// against an arithmetic reference model.
module tb_shift_reg_lr_ctrl;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          load;
  logic          shift_left_right;
  logic [W-1:0]  data_in;
  logic [CW-1:0] shift_cnt;
  logic          serial_in;
  logic          rot_i;
  logic [W-1:0]  q;
  logic          serial_out;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  shift_reg_lr_ctrl #(.REG_WIDTH(W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .load             (load),
    .shift_left_right (shift_left_right),
    .data_in          (data_in),
    .shift_cnt        (shift_cnt),
    .serial_in        (serial_in),
`ifdef SHIFT_REG_ROTATE_EN
    .rotate           (rot_i),
`endif
    .q                (q),
    .serial_out       (serial_out),
    .busy             (busy),
    .done             (done)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         ld;
    logic         dir;
    logic [W-1:0] data;
    int           cnt;
    logic         si;
    logic [W-1:0] exp_q;
    logic         exp_so;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command from a negedge and wait (bounded) for done.
  task automatic run_cmd(input logic ld, input logic dir, input logic [W-1:0] data,
                         input int cnt, input logic si, output int lat);
    cmd_valid        = 1'b1;
    load             = ld;
    shift_left_right = dir;
    data_in          = data;
    shift_cnt        = CW'(cnt);
    serial_in        = si;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!done && lat < cnt + 4) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Reference model state (cycle level, integer arithmetic)
  int   m_q, m_so, m_left, m_done;
  logic m_dir, m_rot;

  initial begin
    int lat;
    rst_n = 1'b0; cmd_valid = 1'b0; load = 1'b0; shift_left_right = 1'b0;
    data_in = '0; shift_cnt = '0; serial_in = 1'b0; rot_i = 1'b0;

    //                ld    dir   data   cnt si    exp_q  so
    vecs[0]  = '{1'b1, 1'b0, 8'h01, 0,  1'b0, 8'h01, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'hA5, 0,  1'b0, 8'hA5, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 1,  1'b0, 8'h4A, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 8'hA5, 0,  1'b0, 8'hA5, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 3,  1'b1, 8'hF4, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 0,  1'b0, 8'hF4, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 8,  1'b0, 8'h00, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 8'h3C, 0,  1'b0, 8'h3C, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 10, 1'b1, 8'hFF, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 2,  1'b0, 8'hFC, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1,  1'b0, 8'h7E, 1'b0};

    repeat (2) @(negedge clk);
    check("reset_q", q, 8'h00);
    check("reset_ready", cmd_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_so", serial_out, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 11; i++) begin
      int exp_lat;
      exp_lat = (vecs[i].ld || vecs[i].cnt == 0) ? 1 : vecs[i].cnt + 1;
      exp_q.push_back(vecs[i].exp_q);
      run_cmd(vecs[i].ld, vecs[i].dir, vecs[i].data, vecs[i].cnt, vecs[i].si, lat);
      check($sformatf("vec%0d_done", i), done, 1'b1);
      check($sformatf("vec%0d_latency", i), lat, exp_lat);
      check($sformatf("vec%0d_q", i), q, exp_q.pop_front());
      check($sformatf("vec%0d_so", i), serial_out, vecs[i].exp_so);
      check($sformatf("vec%0d_ready", i), cmd_ready, 1'b1);
      @(negedge clk);
      check($sformatf("vec%0d_done_single", i), done, 1'b0);
    end

    // Busy window with an ignored load command
    run_cmd(1'b1, 1'b0, 8'hA5, 0, 1'b0, lat);
    @(negedge clk);
    cmd_valid = 1'b1; load = 1'b0; shift_left_right = 1'b0; shift_cnt = 4'd3; serial_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("busy_c0_busy", busy, 1'b1);
    check("busy_c0_ready", cmd_ready, 1'b0);
    check("busy_c0_q", q, 8'hA5);
    load = 1'b1; data_in = 8'hFF;
    @(negedge clk);
    check("busy_c1_q", q, 8'hD2); check("busy_c1_so", serial_out, 1'b1); check("busy_c1_busy", busy, 1'b1);
    @(negedge clk);
    check("busy_c2_q", q, 8'hE9); check("busy_c2_so", serial_out, 1'b0); check("busy_c2_busy", busy, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_c3_q", q, 8'hF4); check("busy_c3_so", serial_out, 1'b1);
    check("busy_c3_done", done, 1'b1); check("busy_c3_busy", busy, 1'b0);
    @(negedge clk);
    check("busy_after_q", q, 8'hF4);

    // Asynchronous reset takes effect mid-cycle
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_q", q, 8'h00);
    check("async_rst_so", serial_out, 1'b0);
    check("async_rst_ready", cmd_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-shift aborts the command
    run_cmd(1'b1, 1'b0, 8'hA5, 0, 1'b0, lat);
    @(negedge clk);
    cmd_valid = 1'b1; load = 1'b0; shift_left_right = 1'b1; shift_cnt = 4'd5; serial_in = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_q", q, 8'h00);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end
    run_cmd(1'b1, 1'b0, 8'h3C, 0, 1'b0, lat);
    check("abort_reload_done", done, 1'b1);
    check("abort_reload_q", q, 8'h3C);
    @(negedge clk);

    // Rotate / fill behaviour
    run_cmd(1'b1, 1'b0, 8'hA5, 0, 1'b0, lat);
    @(negedge clk);
`ifdef SHIFT_REG_ROTATE_EN
    rot_i = 1'b1;
    run_cmd(1'b0, 1'b1, 8'h00, 4, 1'b0, lat);
    rot_i = 1'b0;
    check("rotate_q", q, 8'h5A);
    check("rotate_lat", lat, 5);
    check("rotate_so", serial_out, 1'b0);
`else
    run_cmd(1'b0, 1'b1, 8'h00, 4, 1'b0, lat);
    check("fill_q", q, 8'h50);
    check("fill_lat", lat, 5);
    check("fill_so", serial_out, 1'b0);
`endif
    @(negedge clk);

    // Randomized run against the reference model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_q = 0; m_so = 0; m_left = 0; m_done = 0; m_dir = 1'b0; m_rot = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int fill_bit;
      @(negedge clk);
      check("rand_q", q, m_q[W-1:0]);
      check("rand_so", serial_out, m_so[0]);
      check("rand_busy", busy, (m_left > 0) ? 1'b1 : 1'b0);
      check("rand_ready", cmd_ready, (m_left == 0) ? 1'b1 : 1'b0);
      check("rand_done", done, m_done[0]);
      cmd_valid        = ($urandom_range(0, 2) != 0);
      load             = ($urandom_range(0, 3) == 0);
      shift_left_right = 1'($urandom_range(0, 1));
      data_in          = 8'($urandom_range(0, 255));
      shift_cnt        = 4'($urandom_range(0, 11));
      serial_in        = 1'($urandom_range(0, 1));
`ifdef SHIFT_REG_ROTATE_EN
      rot_i            = 1'($urandom_range(0, 1));
`endif
      if (m_left > 0) begin
        if (m_dir) begin
          fill_bit = m_rot ? (m_q >> (W - 1)) & 1 : int'(serial_in);
          m_so = (m_q >> (W - 1)) & 1;
          m_q  = ((m_q * 2) + fill_bit) % 256;
        end else begin
          fill_bit = m_rot ? (m_q & 1) : int'(serial_in);
          m_so = m_q & 1;
          m_q  = (m_q / 2) + fill_bit * 128;
        end
        m_left = m_left - 1;
        m_done = (m_left == 0) ? 1 : 0;
      end else begin
        m_done = 0;
        if (cmd_valid) begin
          if (load) begin
            m_q = int'(data_in);
            m_done = 1;
          end else if (shift_cnt == 0) begin
            m_done = 1;
          end else begin
            m_left = int'(shift_cnt);
            m_dir  = shift_left_right;
`ifdef SHIFT_REG_ROTATE_EN
            m_rot  = rot_i;
`else
            m_rot  = 1'b0;
`endif
          end
        end
      end
    end
    cmd_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
